ina_i2c_regbank: RTL



---
 rtl/ina_i2c_regbank.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ina_i2c_regbank.sv
// ina_i2c_regbank - I2C-slave register bank for INA-style current/power monitors.
// A bit-level I2C slave FSM plus a pointer register select one of NUM_REGS 16-bit
// registers. Writable slots (WR_MASK) hold config/calibration. Read-only slots
// return a snapshot of meas_data.
// Ports:
//   clk, rst      system clock (>= 16x SCL), synchronous active-high reset
//   scl, sda_in   raw I2C pins, synchronised internally
//   sda_oe        1 = pull SDA low (external open-drain buffer)
//   meas_data     live values for read-only slots, reg i at bits [16*i +: 16]
//   reg_out       writable register contents (read-only slots read as 0)
//   wr_strobe     one-clk pulse on slot i when a write to it commits
//   busy          high from address match until STOP
module ina_i2c_regbank #(
  parameter logic [6:0]             SLAVE_ADDR = 7'h40,
  parameter int                     NUM_REGS   = 6,
  parameter int                     PTR_W      = 3,
  parameter logic [NUM_REGS-1:0]    WR_MASK    = 6'b100001,
  parameter logic [NUM_REGS*16-1:0] RESET_VALS = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h399F},
  parameter bit                     AUTO_INC   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  input  logic                     sda_in,
  output logic                     sda_oe,
  input  logic [NUM_REGS*16-1:0]   meas_data,
  output logic [NUM_REGS*16-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_strobe,
  output logic                     busy
);

  localparam logic [3:0] S_IDLE      = 4'd0,  S_ADDR      = 4'd1,
                         S_ADDR_ACK  = 4'd2,  S_PTR       = 4'd3,
                         S_PTR_ACK   = 4'd4,  S_WMSB      = 4'd5,
                         S_WMSB_ACK  = 4'd6,  S_WLSB      = 4'd7,
                         S_WLSB_ACK  = 4'd8,  S_RMSB      = 4'd9,
                         S_RMSB_MACK = 4'd10, S_RLSB      = 4'd11,
                         S_RLSB_MACK = 4'd12, S_WAIT_STOP = 4'd13;

  localparam logic [7:0]       NREGS8   = 8'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

  // [0],[1] synchronise; [2] is the previous value for edge detection.
  // Reset to 1 so an idle bus does not look like an edge.
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] & scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] & scl_q[2] &  sda_q[1] & ~sda_q[2];

  logic [3:0]                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [7:0]                  shift_q, shift_d;
  logic [7:0]                  msb_q, msb_d;
  logic [15:0]                 tx_q, tx_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic                        rw_q, rw_d;
  logic                        mack_q, mack_d;
  logic                        extra_q, extra_d;   // LSB already committed, ignore further bytes
  logic                        sda_oe_q, sda_oe_d;
  logic                        busy_q, busy_d;
  logic [NUM_REGS-1:0]         wr_strobe_q, wr_strobe_d;
  logic [NUM_REGS-1:0][15:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0][15:0]   meas_w;

  assign meas_w = meas_data;

  // Snapshot source: after a master ACK of the LSB the next word comes from the
  // advanced pointer, otherwise from the current pointer.
  logic [PTR_W-1:0] ptr_inc, snap_ptr;
  logic [15:0]      rd_word;
  assign ptr_inc  = !AUTO_INC ? ptr_q : (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
  assign snap_ptr = (state_q == S_RLSB_MACK) ? ptr_inc : ptr_q;
  assign rd_word  = WR_MASK[snap_ptr] ? regs_q[snap_ptr] : meas_w[snap_ptr];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    msb_d       = msb_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    extra_d     = extra_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    if (start_det) begin
      state_d  = S_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      extra_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WMSB, S_WLSB: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            case (state_q)
              S_ADDR: begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                  rw_d     = shift_q[0];
                  if (shift_q[0]) tx_d = rd_word;
                  state_d  = S_ADDR_ACK;
                end else begin
                  state_d  = S_WAIT_STOP;
                end
              end
              S_PTR: begin
                if (shift_q < NREGS8) begin
                  sda_oe_d = 1'b1;
                  ptr_d    = shift_q[PTR_W-1:0];
                  state_d  = S_PTR_ACK;
                end else begin
                  state_d  = S_WAIT_STOP;
                end
              end
              S_WMSB: begin
                sda_oe_d = 1'b1;
                msb_d    = shift_q;
                state_d  = S_WMSB_ACK;
              end
              default: begin  // S_WLSB
                sda_oe_d = 1'b1;
                state_d  = S_WLSB_ACK;
                if (!extra_q && WR_MASK[ptr_q]) begin
                  regs_d[ptr_q]      = {msb_q, shift_q};
                  wr_strobe_d[ptr_q] = 1'b1;
                end
                extra_d = 1'b1;
              end
            endcase
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          sda_oe_d = rw_q ? ~tx_q[15] : 1'b0;
          state_d  = rw_q ? S_RMSB : S_PTR;
        end
        S_PTR_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          extra_d  = 1'b0;
          state_d  = S_WMSB;
        end
        S_WMSB_ACK, S_WLSB_ACK: if (scl_fall) begin
          // Bytes after the LSB land back in WLSB with extra_q set: ACKed, dropped.
          sda_oe_d = 1'b0;
          state_d  = S_WLSB;
        end
        S_RMSB, S_RLSB: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = (state_q == S_RMSB) ? S_RMSB_MACK : S_RLSB_MACK;
            end else begin
              sda_oe_d = (state_q == S_RMSB) ? ~tx_q[4'd15 - cnt_q] : ~tx_q[4'd7 - cnt_q];
            end
          end
        end
        S_RMSB_MACK, S_RLSB_MACK: begin
          if (scl_rise) begin
            mack_d = ~sda_s;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d = S_WAIT_STOP;
            end else if (state_q == S_RMSB_MACK) begin
              sda_oe_d = ~tx_q[7];
              state_d  = S_RLSB;
            end else begin
              ptr_d    = ptr_inc;
              tx_d     = rd_word;
              sda_oe_d = ~rd_word[15];
              state_d  = S_RMSB;
            end
          end
        end
        default: ;  // IDLE, WAIT_STOP: wait for START/STOP
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      msb_q       <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      extra_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= WR_MASK[i] ? RESET_VALS[i*16 +: 16] : 16'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      msb_q       <= msb_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      extra_q     <= extra_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      regs_q      <= regs_d;
    end
  end

  // Read-only slots are never written, so they stay at 0 here.
  assign reg_out   = regs_q;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;

endmodule
